// File: rtl/ltc2145_delay_calibrator_if.sv
// Calibrator bus: start request, per-lane captured bits in; delay-load strobes and results out.
// Latency: none (wires only); all timing is owned by the calibrator behind the slave modport.
// Backpressure: none; start is a single-cycle request, ignored by the slave while it is busy.
//
// Signals:
//   start        init logic -> calibrator, one-cycle calibration request
//   lane_data    capture    -> calibrator, one captured bit per lane
//   dly_ld       calibrator -> IDELAYE2 LD, one-hot per lane
//   dly_cntvalue calibrator -> IDELAYE2 CNTVALUEIN, shared by all lanes
//   busy/done    calibrator status; done is a one-cycle pulse
//   cal_ok       all lanes found an eye; fail_mask marks the lanes that did not
//   tap_result   final tap per lane, lane i in bits [5i+4:5i]
interface ltc2145_delay_calibrator_if #(
  parameter int LANES = 8
);
  logic               start;
  logic [LANES-1:0]   lane_data;
  logic [LANES-1:0]   dly_ld;
  logic [4:0]         dly_cntvalue;
  logic               busy;
  logic               done;
  logic               cal_ok;
  logic [LANES-1:0]   fail_mask;
  logic [5*LANES-1:0] tap_result;

  // Calibrator side
  modport slave (
    input  start, lane_data,
    output dly_ld, dly_cntvalue, busy, done, cal_ok, fail_mask, tap_result
  );

  // Init/config and capture side
  modport master (
    output start, lane_data,
    input  dly_ld, dly_cntvalue, busy, done, cal_ok, fail_mask, tap_result
  );
endinterface

// File: rtl/ltc2145_delay_calibrator.sv
// Trains LTC2145 LVDS lane delay taps: sweeps taps 0-31 per lane against the 1010 test pattern, loads eye centre.
// Latency: start->busy 1 cycle; done at 1 + LANES*(32*(SETTLE+CHECK+3)+1) cycles after start.
// Backpressure: none; start is ignored while busy or in the done cycle.
//
// Ports:
//   i_sample_clk  capture clock, all logic on its rising edge
//   i_reset       asynchronous active-high reset
//   cal           slave modport of ltc2145_delay_calibrator_if (start/lane_data in, delay strobes and results out)
module ltc2145_delay_calibrator #(
  parameter int LANES         = 8,
  parameter int SETTLE_CYCLES = 8,
  parameter int CHECK_CYCLES  = 64,
  parameter int MIN_EYE       = 4,
  parameter int DEFAULT_TAP   = 16
) (
  input  logic                          i_sample_clk,
  input  logic                          i_reset,
  ltc2145_delay_calibrator_if.slave     cal
);

  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CMAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_CYCLES);
  localparam logic [LW-1:0] LANE_LAST   = LW'(LANES - 1);
  localparam logic [5:0]    MIN_LEN     = 6'(MIN_EYE);
  localparam logic [4:0]    DEF_TAP     = 5'(DEFAULT_TAP);
  localparam logic [4:0]    TAP_LAST    = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_FINAL, S_DONE
  } state_t;

  state_t r_state, w_state_nx;

  // Sweep datapath
  logic [LW-1:0] r_lane;
  logic [4:0]    r_tap;
  logic [CW-1:0] r_cnt;
  logic          r_prev;
  logic          r_err;
  logic [4:0]    r_cur_start, r_best_start;
  logic [5:0]    r_cur_len,   r_best_len;

  // Registered outputs
  logic [LANES-1:0]   r_dly_ld;
  logic [4:0]         r_dly_cntvalue;
  logic               r_busy, r_done, r_cal_ok;
  logic [LANES-1:0]   r_fail_mask;
  logic [5*LANES-1:0] r_tap_result;

  // Next values for the registered outputs
  logic [LANES-1:0]   w_dly_ld_nx;
  logic [4:0]         w_dly_cntvalue_nx;
  logic               w_cal_ok_nx;
  logic [LANES-1:0]   w_fail_mask_nx;
  logic [5*LANES-1:0] w_tap_result_nx;

  logic          w_bit;
  logic          w_pass;
  logic [LW-1:0] w_lane_inc;
  logic [4:0]    w_cur_start_nx, w_best_start_nx;
  logic [5:0]    w_cur_len_nx,   w_best_len_nx;
  logic          w_eye_ok;
  logic [4:0]    w_half;
  logic [4:0]    w_centre;

  assign w_bit      = cal.lane_data[r_lane];
  assign w_pass     = ~r_err;
  assign w_lane_inc = r_lane + 1'b1;

  // Window tracking for the tap being evaluated. The centre is derived from
  // the post-update best window so the last tap (31) can still extend it
  // and the FINAL load is registered out in the FINAL cycle itself.
  always_comb begin
    w_cur_start_nx  = r_cur_start;
    w_cur_len_nx    = r_cur_len;
    w_best_start_nx = r_best_start;
    w_best_len_nx   = r_best_len;
    if (w_pass) begin
      if (r_cur_len == 6'd0) w_cur_start_nx = r_tap;
      w_cur_len_nx = r_cur_len + 6'd1;
      // Strictly greater: an equal-length later window never replaces the earlier one
      if (w_cur_len_nx > r_best_len) begin
        w_best_start_nx = w_cur_start_nx;
        w_best_len_nx   = w_cur_len_nx;
      end
    end else begin
      w_cur_len_nx = 6'd0;
    end
  end

  assign w_eye_ok = (w_best_len_nx >= MIN_LEN);
  assign w_half   = 5'((w_best_len_nx - 6'd1) >> 1);
  assign w_centre = w_eye_ok ? (w_best_start_nx + w_half) : DEF_TAP;

  // State register
  always_ff @(posedge i_sample_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (cal.start) w_state_nx = S_LOAD;
      S_LOAD:   w_state_nx = S_SETTLE;
      S_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nx = S_CHECK;
      S_CHECK:  if (r_cnt == CHECK_LAST) w_state_nx = S_EVAL;
      S_EVAL:   w_state_nx = (r_tap == TAP_LAST) ? S_FINAL : S_LOAD;
      S_FINAL:  w_state_nx = (r_lane == LANE_LAST) ? S_DONE : S_LOAD;
      S_DONE:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Output logic: computed one cycle ahead so the registered strobes line up
  // with the LOAD/FINAL state they belong to.
  always_comb begin
    w_dly_ld_nx       = '0;
    w_dly_cntvalue_nx = r_dly_cntvalue;
    w_cal_ok_nx       = r_cal_ok;
    w_fail_mask_nx    = r_fail_mask;
    w_tap_result_nx   = r_tap_result;
    case (r_state)
      S_IDLE: begin
        if (cal.start) begin
          w_cal_ok_nx       = 1'b0;
          w_fail_mask_nx    = '0;
          w_tap_result_nx   = '0;
          w_dly_ld_nx[0]    = 1'b1;
          w_dly_cntvalue_nx = 5'd0;
        end
      end
      S_EVAL: begin
        w_dly_ld_nx[r_lane] = 1'b1;
        if (r_tap == TAP_LAST) begin
          w_dly_cntvalue_nx = w_centre;
          w_tap_result_nx[int'(r_lane)*5 +: 5] = w_centre;
          if (!w_eye_ok) w_fail_mask_nx[r_lane] = 1'b1;
        end else begin
          w_dly_cntvalue_nx = r_tap + 5'd1;
        end
      end
      S_FINAL: begin
        if (r_lane == LANE_LAST) begin
          w_cal_ok_nx = ~|r_fail_mask;
        end else begin
          w_dly_ld_nx[w_lane_inc] = 1'b1;
          w_dly_cntvalue_nx       = 5'd0;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge i_sample_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dly_ld       <= '0;
      r_dly_cntvalue <= 5'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_cal_ok       <= 1'b0;
      r_fail_mask    <= '0;
      r_tap_result   <= '0;
    end else begin
      r_dly_ld       <= w_dly_ld_nx;
      r_dly_cntvalue <= w_dly_cntvalue_nx;
      r_busy         <= (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);
      r_done         <= (w_state_nx == S_DONE);
      r_cal_ok       <= w_cal_ok_nx;
      r_fail_mask    <= w_fail_mask_nx;
      r_tap_result   <= w_tap_result_nx;
    end
  end

  // Sweep datapath
  always_ff @(posedge i_sample_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lane       <= '0;
      r_tap        <= 5'd0;
      r_cnt        <= '0;
      r_prev       <= 1'b0;
      r_err        <= 1'b0;
      r_cur_start  <= 5'd0;
      r_cur_len    <= 6'd0;
      r_best_start <= 5'd0;
      r_best_len   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cal.start) begin
            r_lane       <= '0;
            r_tap        <= 5'd0;
            r_cur_start  <= 5'd0;
            r_cur_len    <= 6'd0;
            r_best_start <= 5'd0;
            r_best_len   <= 6'd0;
          end
        end
        S_LOAD: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        S_SETTLE: begin
          r_cnt <= (r_cnt == SETTLE_LAST) ? '0 : r_cnt + 1'b1;
        end
        S_CHECK: begin
          // Count 0 only primes r_prev; every later cycle must see a toggle
          r_prev <= w_bit;
          if ((r_cnt != '0) && (w_bit == r_prev)) r_err <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
        end
        S_EVAL: begin
          r_cur_start  <= w_cur_start_nx;
          r_cur_len    <= w_cur_len_nx;
          r_best_start <= w_best_start_nx;
          r_best_len   <= w_best_len_nx;
          if (r_tap != TAP_LAST) r_tap <= r_tap + 5'd1;
        end
        S_FINAL: begin
          if (r_lane != LANE_LAST) begin
            r_lane     <= w_lane_inc;
            r_tap      <= 5'd0;
            r_cur_len  <= 6'd0;
            r_best_len <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cal.dly_ld       = r_dly_ld;
  assign cal.dly_cntvalue = r_dly_cntvalue;
  assign cal.busy         = r_busy;
  assign cal.done         = r_done;
  assign cal.cal_ok       = r_cal_ok;
  assign cal.fail_mask    = r_fail_mask;
  assign cal.tap_result   = r_tap_result;

endmodule

// File: tb/tb_ltc2145_delay_calibrator.sv
// Directed bench for ltc2145_delay_calibrator with default timing parameters.
// Models each lane's IDELAY tap and the ADC 1010 pattern; a lane toggles only at its passing taps.
// Checks reset values, cycle-exact done, per-lane results, ignored starts and mid-run reset.
module tb_ltc2145_delay_calibrator;
  localparam int LANES = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ltc2145_delay_calibrator_if #(.LANES(LANES)) cal_if();

  ltc2145_delay_calibrator #(
    .LANES(LANES), .SETTLE_CYCLES(8), .CHECK_CYCLES(64), .MIN_EYE(4), .DEFAULT_TAP(16)
  ) dut (
    .i_sample_clk(clk),
    .i_reset(rst),
    .cal(cal_if)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int mode    = 0;
  int multi_err = 0;
  int cyc;
  logic tog = 1'b0;
  logic [4:0] lane_tap [LANES] = '{default: 5'd0};

  // Hand-computed centres for the mixed-pattern runs
  logic [4:0] exp_mixed [LANES] = '{5'd12, 5'd29, 5'd17, 5'd16, 5'd16, 5'd6, 5'd15, 5'd15};

  // Passing taps per lane: mode 0 is ideal data, mode 1 gives each lane its own eye
  function automatic bit lane_ok(input int m, input int l, input int t);
    if (m == 0) return 1'b1;
    case (l)
      0:       return (t >= 5 && t <= 20);
      1:       return (t >= 28);
      2:       return (t >= 2 && t <= 6) || (t >= 10 && t <= 25);
      3:       return 1'b0;
      4:       return (t >= 29);
      5:       return (t >= 3 && t <= 10) || (t >= 20 && t <= 27);
      default: return 1'b1;
    endcase
  endfunction

  // IDELAY + ADC model: latch loaded taps, then drive toggling or stuck-low data
  always @(negedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (cal_if.dly_ld[i] === 1'b1) lane_tap[i] = cal_if.dly_cntvalue;
    if (!$onehot0(cal_if.dly_ld)) multi_err++;
    tog = ~tog;
    for (int i = 0; i < LANES; i++)
      cal_if.lane_data[i] = lane_ok(mode, i, int'(lane_tap[i])) ? tog : 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dly_ld"},     cal_if.dly_ld, 0);
    chk({tag, "_cntvalue"},   cal_if.dly_cntvalue, 0);
    chk({tag, "_busy"},       cal_if.busy, 0);
    chk({tag, "_done"},       cal_if.done, 0);
    chk({tag, "_cal_ok"},     cal_if.cal_ok, 0);
    chk({tag, "_fail_mask"},  cal_if.fail_mask, 0);
    chk({tag, "_tap_result"}, cal_if.tap_result, 0);
  endtask

  task automatic check_results(input int m, input string tag);
    logic [4:0] e;
    for (int i = 0; i < LANES; i++) begin
      e = (m == 0) ? 5'd15 : exp_mixed[i];
      chk($sformatf("%s_tap%0d", tag, i), cal_if.tap_result[i*5 +: 5], e);
      chk($sformatf("%s_idelay%0d", tag, i), lane_tap[i], e);
    end
    chk({tag, "_fail_mask"}, cal_if.fail_mask, (m == 0) ? 8'h00 : 8'h18);
    chk({tag, "_cal_ok"}, cal_if.cal_ok, (m == 0) ? 1'b1 : 1'b0);
    chk({tag, "_busy_at_done"}, cal_if.busy, 0);
  endtask

  // Pulses start in the current cycle and follows the run cycle by cycle.
  // Extra start pulses at cycles 50 and 3000 must be ignored. Returns the
  // cycle of done (start cycle = 0), or -1 on timeout / early stop.
  task automatic run_cal(input string tag, input int stop_at, output int done_cyc);
    int n;
    n = 0;
    done_cyc = -1;
    cal_if.start = 1'b1;
    @(posedge clk);
    while (n < 25000) begin
      @(negedge clk);
      n++;
      cal_if.start = (n == 50 || n == 3000);
      if (n == 1) chk({tag, "_busy_cycle1"}, cal_if.busy, 1);
      if (stop_at != 0 && n == stop_at) break;
      if (cal_if.done === 1'b1) begin
        done_cyc = n;
        break;
      end
    end
    cal_if.start = 1'b0;
  endtask

  initial begin
    cal_if.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Run 1: ideal data on every lane
    mode = 0;
    run_cal("ideal", 0, cyc);
    chk("ideal_done_cycle", cyc, 19209);
    check_results(0, "ideal");

    // start during the done cycle is ignored
    cal_if.start = 1'b1;
    @(negedge clk);
    chk("done_start_busy", cal_if.busy, 0);
    chk("done_start_done", cal_if.done, 0);
    chk("cal_ok_held", cal_if.cal_ok, 1);

    // Run 2: start in the cycle after done is accepted; per-lane eyes
    mode = 1;
    run_cal("mixed", 0, cyc);
    chk("mixed_done_cycle", cyc, 19209);
    check_results(1, "mixed");
    @(negedge clk);

    // Run 3: reset during lane 4 CHECK (lane 4 first tap CHECK spans cycles 9614-9678)
    run_cal("rst", 9620, cyc);
    chk("pre_reset_busy", cal_if.busy, 1);
    chk("pre_reset_taps", cal_if.tap_result[19:0], {5'd16, 5'd17, 5'd29, 5'd12});
    rst = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    check_reset_vals("mid_reset_edge");
    chk("idelay_kept", lane_tap[0], 5'd12);
    rst = 1'b0;
    @(negedge clk);

    // Run 4: fresh start after reset restarts from lane 0
    run_cal("fresh", 0, cyc);
    chk("fresh_done_cycle", cyc, 19209);
    check_results(1, "fresh");

    chk("dly_ld_onehot0", multi_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
